sudoku_checker: RTL
===================

# sudoku_checker

Validates a 9x9 Sudoku board held in the board-loader register array, downstream of the loader. On `start` it reads every cell through a synchronous one-cycle read port and scans all 27 constraint groups: 9 rows, then 9 columns, then 9 boxes. It reports whether the board is legal, whether it is full, and the first conflict found. Its results drive the status outputs of the top-level tile.

## Interface
- Parameters: none. Board geometry comes from fixed package constants.
- `clk` input 1 — single clock.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `start` input 1 — request a scan. Sampled only while `busy`=0.
- `rd_en` output 1 — read strobe to the board array.
- `rd_row` output 4 — read row, 0..8.
- `rd_col` output 4 — read column, 0..8.
- `rd_data` input 4 — cell value. Valid the cycle after `rd_en`. 0 means empty, 1..9 is a digit, 10..15 is illegal.
- `busy` output 1 — scan in progress.
- `done` output 1 — one-cycle pulse when results are updated.
- `board_ok` output 1 — no duplicates and no illegal values.
- `board_full` output 1 — no cell equals 0.
- `bad_value` output 1 — at least one cell is in 10..15.
- `err_kind` output 2 — kind of the first duplicate: 0 none, 1 row, 2 column, 3 box.
- `err_idx` output 4 — group index of the first duplicate, 0..8.
- `err_val` output 4 — digit duplicated in the first conflict.

## Operation
- **FSM states:** IDLE → SCAN → DRAIN → DONE → IDLE.
- **IDLE:** on `start`=1, clear all result flags and enter SCAN.
- **SCAN:** issues 243 reads, one per cycle, with `rd_en`=1.
  - Group counter g runs 0..26; cell counter c runs 0..8. c wraps to 0 and g increments.
  - g 0..8 selects row g, read in column order: (g, c).
  - g 9..17 selects column g-9, read in row order: (c, g-9).
  - g 18..26 selects box b=g-18, row-major within the box: (3*(b/3)+c/3, 3*(b%3)+c%3).
  - After the read at g=26, c=8, go to DRAIN.
- **DRAIN:** one cycle in which the final `rd_data` is evaluated. Then go to DONE.
- **DONE:** assert `done`=1 for one cycle, then go to IDLE.
- **Data pipeline:** the group/cell tags are delayed one cycle to match `rd_data`.
  - A 9-bit seen mask is kept per group and cleared when tagged c=0.
  - Value 0: ignored for duplicates; clears the running full flag.
  - Value 10..15: sets `bad_value`; excluded from the mask.
  - Value 1..9 with its mask bit already set: a duplicate.
- **First-conflict capture:** only the first duplicate of a scan is recorded in `err_kind`/`err_idx`/`err_val`; later duplicates are ignored. Because rows are scanned first, a digit duplicated in both a row and a box reports as a row conflict.
- **Final results:**
  - `board_ok` = no duplicate and no `bad_value`.
  - `board_full` = running full flag.
  - Results hold until the next accepted `start`.
- `start` while `busy`=1 is ignored.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, counters 0.
- **Reset mid-scan:** returns everything to reset values immediately; no `done` is produced.
- **Cycle numbering:** cycle 0 is the cycle in which `start` is accepted.
  - `busy`=1 from cycle 1 through cycle 244.
  - `rd_en`=1 in cycles 1..243; cell n is addressed in cycle n+1.
  - `rd_data` for cell n is evaluated in cycle n+2; the last is in cycle 244 (DRAIN).
  - Results and `done`=1 appear in cycle 245, with `busy`=0.
- **Back-to-back start:** `start` in cycle 245 is accepted, so back-to-back scans run with period 245.
- **Read port off:** `rd_row`/`rd_col` are 0 whenever `rd_en`=0.

## Structure
- **Shared package `sudoku_pkg`:**
  - Constants N=9, NUM_GROUPS=27, NUM_CELLS=243.
  - Group-kind enum: NONE, ROW, COL, BOX.
  - Cell value type, 4 bits.
- **Sub-module `sudoku_addr_gen`:** combinational (g, c) → (`rd_row`, `rd_col`) mapping, kept separate so it can be tested exhaustively.
- **Top of this block:** FSM, counters, tag pipeline, mask and result registers.

## Test plan
- **Solved board:** a known solved grid, then `start` → `done` in cycle 245; `board_ok`=1, `board_full`=1, `err_kind`=0, `bad_value`=0.
- **Empty board:** all cells 0 → `board_ok`=1, `board_full`=0.
- **Row duplicate:** digit 5 at (3,0) and (3,7), rest of the board legal but partial → `err_kind`=1, `err_idx`=3, `err_val`=5, `board_ok`=0.
- **Box duplicate:** 7 at (0,0) and (2,2), no row or column clash → `err_kind`=3, `err_idx`=0, `err_val`=7.
- **Illegal value:** 12 at (8,8) → `bad_value`=1, `board_ok`=0, `err_kind`=0.
- **Control and reset:**
  - `start` held high through the scan → exactly one scan per 245 cycles.
  - `rst_n` low in cycle 100 → `busy`=0 and `rd_en`=0 at once, no `done`.
  - A new `start` after reset completes in 245 cycles.

Source files
------------

// File: rtl/sudoku_pkg.sv
// sudoku_pkg: board geometry, group kinds, cell type and group-index helpers
package sudoku_pkg;
    localparam int N          = 9;
    localparam int NUM_GROUPS = 27;
    localparam int NUM_CELLS  = 243;

    typedef enum logic [1:0] {NONE = 2'd0, ROW = 2'd1, COL = 2'd2, BOX = 2'd3} group_kind_t;
    typedef logic [3:0] cell_t;

    // groups 0..8 are rows, 9..17 columns, 18..26 boxes
    function automatic group_kind_t group_kind(input logic [4:0] g);
        return g < 5'd9 ? ROW : g < 5'd18 ? COL : BOX;
    endfunction

    function automatic logic [3:0] group_idx(input logic [4:0] g);
        return g < 5'd9 ? g[3:0] : g < 5'd18 ? 4'(g - 5'd9) : 4'(g - 5'd18);
    endfunction

    function automatic logic [1:0] div3(input logic [3:0] x);
        return x >= 4'd6 ? 2'd2 : x >= 4'd3 ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [3:0] mul3(input logic [1:0] x);
        return {2'b00, x} + {1'b0, x, 1'b0};
    endfunction

    function automatic logic [1:0] mod3(input logic [3:0] x);
        return 2'(x - mul3(div3(x)));
    endfunction
endpackage

// File: rtl/sudoku_addr_gen.sv
// sudoku_addr_gen: maps group/cell counters to a board read address
//   en     : read enable; address forced to 0 when low
//   g, c   : group 0..26 and cell-within-group 0..8
//   rd_row : board row 0..8
//   rd_col : board column 0..8
module sudoku_addr_gen
    import sudoku_pkg::*;
(
    input  logic       en,
    input  logic [4:0] g,
    input  logic [3:0] c,
    output logic [3:0] rd_row,
    output logic [3:0] rd_col
);
    logic [3:0]  idx;
    group_kind_t kind;

    // boxes are walked row-major: box b covers rows 3*(b/3).., cols 3*(b%3)..
    always_comb begin
        idx    = group_idx(g);
        kind   = group_kind(g);
        rd_row = !en ? 4'd0 : kind == ROW ? idx : kind == COL ? c : mul3(div3(idx)) + {2'b00, div3(c)};
        rd_col = !en ? 4'd0 : kind == ROW ? c : kind == COL ? idx : mul3(mod3(idx)) + {2'b00, mod3(c)};
    end
endmodule

// File: rtl/sudoku_checker.sv
// sudoku_checker: scans all 27 rows/columns/boxes of a 9x9 board for legality
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : request a scan (ignored while busy)
//   rd_en/rd_row/rd_col: read port to the board array, data returns next cycle
//   rd_data            : cell value, 0 empty, 1..9 digit, 10..15 illegal
//   busy, done         : scan in progress, one-cycle result pulse
//   board_ok/full      : no duplicates or illegal values / no empty cells
//   bad_value          : some cell held 10..15
//   err_kind/idx/val   : group kind, group index and digit of the first duplicate
module sudoku_checker
    import sudoku_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       rd_en,
    output logic [3:0] rd_row,
    output logic [3:0] rd_col,
    input  cell_t      rd_data,
    output logic       busy,
    output logic       done,
    output logic       board_ok,
    output logic       board_full,
    output logic       bad_value,
    output logic [1:0] err_kind,
    output logic [3:0] err_idx,
    output logic [3:0] err_val
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic        dup;
        logic        bad;
        logic        full;
        group_kind_t kind;
        logic [3:0]  idx;
        cell_t       val;
    } run_t;

    localparam run_t RUN_CLR = '{dup: 1'b0, bad: 1'b0, full: 1'b1, kind: NONE, idx: 4'd0, val: 4'd0};

    state_t     state;
    logic [4:0] g, g_q;
    logic [3:0] c, c_q;
    logic       v_q;
    logic [8:0] mask, base, bit_v;
    logic       is_dup;
    run_t       run, nxt;

    assign rd_en = state == SCAN;
    assign busy  = state == SCAN || state == DRAIN;
    assign done  = state == DONE;

    sudoku_addr_gen u_addr (
        .en    (rd_en),
        .g     (g),
        .c     (c),
        .rd_row(rd_row),
        .rd_col(rd_col)
    );

    // g_q/c_q/v_q tag the data returning this cycle; a tag with c_q=0 starts a fresh group
    always_comb begin
        base   = c_q == 4'd0 ? 9'd0 : mask;
        bit_v  = v_q && rd_data != 4'd0 && rd_data <= 4'd9 ? 9'd1 << (rd_data - 4'd1) : 9'd0;
        is_dup = |(base & bit_v);
        nxt      = run;
        nxt.bad  = run.bad | (v_q && rd_data > 4'd9);
        nxt.full = run.full & !(v_q && rd_data == 4'd0);
        nxt.dup  = run.dup | is_dup;
        if (is_dup && !run.dup) begin
            nxt.kind = group_kind(g_q);
            nxt.idx  = group_idx(g_q);
            nxt.val  = rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            g          <= 5'd0;
            c          <= 4'd0;
            g_q        <= 5'd0;
            c_q        <= 4'd0;
            v_q        <= 1'b0;
            mask       <= 9'd0;
            run        <= RUN_CLR;
            board_ok   <= 1'b0;
            board_full <= 1'b0;
            bad_value  <= 1'b0;
            err_kind   <= 2'd0;
            err_idx    <= 4'd0;
            err_val    <= 4'd0;
        end else begin
            v_q  <= rd_en;
            g_q  <= g;
            c_q  <= c;
            mask <= v_q ? base | bit_v : mask;
            run  <= nxt;
            case (state)
                IDLE, DONE: begin
                    state <= start ? SCAN : IDLE;
                    if (start) begin
                        run        <= RUN_CLR;
                        board_ok   <= 1'b0;
                        board_full <= 1'b0;
                        bad_value  <= 1'b0;
                        err_kind   <= 2'd0;
                        err_idx    <= 4'd0;
                        err_val    <= 4'd0;
                    end
                end
                SCAN: begin
                    c <= c == 4'(N - 1) ? 4'd0 : c + 4'd1;
                    g <= c != 4'(N - 1) ? g : g == 5'(NUM_GROUPS - 1) ? 5'd0 : g + 5'd1;
                    state <= c == 4'(N - 1) && g == 5'(NUM_GROUPS - 1) ? DRAIN : SCAN;
                end
                DRAIN: begin
                    state      <= DONE;
                    board_ok   <= !nxt.dup && !nxt.bad;
                    board_full <= nxt.full;
                    bad_value  <= nxt.bad;
                    err_kind   <= nxt.kind;
                    err_idx    <= nxt.idx;
                    err_val    <= nxt.val;
                end
            endcase
        end
    end
endmodule
